// File: rtl/matrix_demo_axil_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_demo_pkg
//  Description : Shared types and helpers for the matrix_demo AXI4-Lite
//                register slave. Holds the response code, register index
//                names, the write and read FSM state types, and the byte-lane
//                merge function.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_demo_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Register map indices, as seen by the Ising sampler core
  localparam int REG_CTRL = 0;
  localparam int REG_SEED = 1;
  localparam int REG_ITER = 2;
  localparam int REG_STAT = 3;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_val[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_demo_axil_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_demo_axil_slave_if
//  Description : AXI4-Lite bus bundle between the master VIP/BFM and the
//                matrix_demo register slave.
//  Modports    : master - drives AW/W/AR channels and B/R ready
//                slave  - drives the readies of AW/W/AR and the B/R channels
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_demo_axil_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface
`default_nettype wire

// File: rtl/matrix_demo_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_demo_axil_slave
//  Description : AXI4-Lite slave holding four 32-bit configuration registers
//                (0x0, 0x4, 0x8, 0xC) for the Ising sampler core. Independent
//                write and read FSMs, one outstanding transaction each.
//  Ports       : S_AXI_ACLK     - clock
//                S_AXI_ARESETN  - asynchronous active-low reset
//                s_axi          - AXI4-Lite slave modport
//                slv_reg_o      - register k at bits [32k+31:32k]
//                reg_wr_pulse_o - one-cycle write strobe per register
//                                 (only with MATRIX_DEMO_WR_PULSE_EN defined)
//  Option      : MATRIX_DEMO_WR_PULSE_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_demo_axil_slave
  import matrix_demo_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  wire logic                               S_AXI_ACLK,
  input  wire logic                               S_AXI_ARESETN,
  matrix_demo_axil_slave_if.slave                 s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]  slv_reg_o
`ifdef MATRIX_DEMO_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]                     reg_wr_pulse_o
`endif
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t                     wr_state_q, wr_state_d;
  logic                          awready_q,  awready_d;
  logic                          wready_q,   wready_d;
  logic                          bvalid_q,   bvalid_d;
  logic                          commit_q,   commit_d;
  logic [IDX_W-1:0]              wr_idx_q,   wr_idx_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [3:0]                    wstrb_q,    wstrb_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];
`ifdef MATRIX_DEMO_WR_PULSE_EN
  logic [NUM_REGS-1:0]           pulse_q,    pulse_d;
`endif

  rd_state_t                     rd_state_q, rd_state_d;
  logic                          arready_q,  arready_d;
  logic                          rvalid_q,   rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,    rdata_d;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic r_hs;
  logic b_hs;

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid  & wready_q;
  assign b_hs  = bvalid_q      & s_axi.bready;
  assign ar_hs = s_axi.arvalid & arready_q;
  assign r_hs  = rvalid_q      & s_axi.rready;

  // --------------------------------------------------------------------------
  // Write FSM
  // Readies are registered so they stay low through reset and rise on the
  // first edge after release. commit_q marks "address and data both held";
  // the register update happens on the edge after capture.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    commit_d   = commit_q;
    wr_idx_d   = wr_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end
`ifdef MATRIX_DEMO_WR_PULSE_EN
    pulse_d = '0;
`endif

    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs) begin
          wr_idx_d  = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          awready_d = 1'b0;
        end
        if (w_hs) begin
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
          wready_d = 1'b0;
        end
        if (aw_hs && w_hs) begin
          // Both halves in one cycle: park in W_HAVE_A with commit pending
          wr_state_d = W_HAVE_A;
          commit_d   = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = W_HAVE_A;
        end else if (w_hs) begin
          wr_state_d = W_HAVE_D;
        end
      end

      W_HAVE_A, W_HAVE_D: begin
        if (commit_q) begin
          regs_d[wr_idx_q] = apply_wstrb(regs_q[wr_idx_q], wdata_q, wstrb_q);
`ifdef MATRIX_DEMO_WR_PULSE_EN
          pulse_d[wr_idx_q] = |wstrb_q;
`endif
          commit_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = W_RESP;
        end else if (wr_state_q == W_HAVE_A && w_hs) begin
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
          wready_d = 1'b0;
          commit_d = 1'b1;
        end else if (wr_state_q == W_HAVE_D && aw_hs) begin
          wr_idx_d  = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
          awready_d = 1'b0;
          commit_d  = 1'b1;
        end
      end

      W_RESP: begin
        // Readies stay low here; W_IDLE raises them one edge later
        if (b_hs) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end

      default: wr_state_d = W_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // RDATA is taken from the current register contents, so a read that
  // coincides with a write returns the pre-write value.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;

    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d    = regs_q[s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2]];
          rvalid_d   = 1'b1;
          arready_d  = 1'b0;
          rd_state_d = R_RESP;
        end
      end

      R_RESP: begin
        if (r_hs) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end

      default: rd_state_d = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      commit_q   <= 1'b0;
      wr_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
`ifdef MATRIX_DEMO_WR_PULSE_EN
      pulse_q    <= '0;
`endif
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      commit_q   <= commit_d;
      wr_idx_q   <= wr_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
`ifdef MATRIX_DEMO_WR_PULSE_EN
      pulse_q    <= pulse_d;
`endif
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_slv_reg
      assign slv_reg_o[k*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs_q[k];
    end
  endgenerate

`ifdef MATRIX_DEMO_WR_PULSE_EN
  assign reg_wr_pulse_o = pulse_q;
`endif

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_matrix_demo_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_demo_axil_slave
//  Description : Directed self-checking bench for matrix_demo_axil_slave.
//                Inputs change on the falling edge; outputs are sampled on
//                the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_demo_axil_slave;

  logic        clk;
  logic        rst_n;
  logic [127:0] slv_reg;
  int          n_checks;
  int          n_pass;

  matrix_demo_axil_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

`ifdef MATRIX_DEMO_WR_PULSE_EN
  logic [3:0] wr_pulse;
  int         pulse_cnt [4] = '{default: 0};
`endif

  matrix_demo_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_REGS(4)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus.slave),
    .slv_reg_o(slv_reg)
`ifdef MATRIX_DEMO_WR_PULSE_EN
    ,
    .reg_wr_pulse_o(wr_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MATRIX_DEMO_WR_PULSE_EN
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_pulse[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Bus drivers (report a timeout through ok; checks live in the test tasks)
  // --------------------------------------------------------------------------
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output bit ok);
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    ok = 1'b1; aw_done = 1'b0; w_done = 1'b0; resp = 2'bxx;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    n = 0;
    while (!(aw_done && w_done)) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      n++;
      if (n > 20) begin ok = 1'b0; break; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bus.bvalid) ok = 1'b0;
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b1;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin @(negedge clk); n++; end
    if (!bus.arready) ok = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (!bus.rvalid) ok = 1'b0;
    d = bus.rdata;
    resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000)
      $display("FAIL reset_readies: got %b want 000", {bus.awready, bus.wready, bus.arready});
    else n_pass++;
    n_checks++;
    if ({bus.bvalid, bus.rvalid} !== 2'b00)
      $display("FAIL reset_valids: got %b want 00", {bus.bvalid, bus.rvalid});
    else n_pass++;
    n_checks++;
    if (slv_reg !== 128'h0 || bus.rdata !== 32'h0)
      $display("FAIL reset_regs: slv %h rdata %h want 0", slv_reg, bus.rdata);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL release_readies: got %b want 111", {bus.awready, bus.wready, bus.arready});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [1:0]  resp;
    logic [31:0] d;
    bit          ok, all_ok;
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp, ok);
      if (!ok || resp !== 2'b00) all_ok = 1'b0;
    end
    n_checks++;
    if (!all_ok) $display("FAIL basic_bresp: a write timed out or BRESP nonzero, want OKAY");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp, ok);
      n_checks++;
      if (!ok || d !== 32'(i + 1) || resp !== 2'b00)
        $display("FAIL basic_read%0d: ok %0d rdata %h rresp %b want %h 00", i, ok, d, resp, 32'(i + 1));
      else n_pass++;
    end
    n_checks++;
    if (slv_reg !== {32'h4, 32'h3, 32'h2, 32'h1})
      $display("FAIL basic_slv_reg: got %h want 00000004000000030000000200000001", slv_reg);
    else n_pass++;
  endtask

  task automatic test_wstrb();
    logic [1:0]  resp;
    logic [31:0] d;
    bit          ok;
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, resp, ok);
    axi_read(4'h4, d, resp, ok);
    n_checks++;
    if (!ok || d !== 32'h00BB00DD)
      $display("FAIL wstrb_partial: rdata %h want 00bb00dd", d);
    else n_pass++;
    // Zero strobe: OKAY response, register untouched
    axi_write(4'h0, 32'hFFFFFFFF, 4'b0000, resp, ok);
    n_checks++;
    if (!ok || resp !== 2'b00)
      $display("FAIL wstrb_zero_resp: ok %0d bresp %b want 00", ok, resp);
    else n_pass++;
    axi_read(4'h0, d, resp, ok);
    n_checks++;
    if (!ok || d !== 32'h1)
      $display("FAIL wstrb_zero_data: rdata %h want 00000001", d);
    else n_pass++;
  endtask

  task automatic test_w_before_aw();
    bit held;
    @(negedge clk);
    @(negedge clk);
    bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    @(negedge clk);
    bus.wvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0 || bus.awready !== 1'b1)
      $display("FAIL wfirst_readies: wready %b awready %b want 0 1", bus.wready, bus.awready);
    else n_pass++;
    @(negedge clk);
    bus.awaddr = 4'hC; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    n_checks++;
    if (bus.bvalid !== 1'b0 || slv_reg[127:96] !== 32'h4)
      $display("FAIL wfirst_capture_edge: bvalid %b reg3 %h want 0 00000004", bus.bvalid, slv_reg[127:96]);
    else n_pass++;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.bvalid !== 1'b1 || slv_reg[127:96] !== 32'h12345678) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL wfirst_bvalid_hold: bvalid %b reg3 %h want 1 12345678", bus.bvalid, slv_reg[127:96]);
    else n_pass++;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    n_checks++;
    if ({bus.bvalid, bus.awready, bus.wready} !== 3'b000)
      $display("FAIL wfirst_after_b: bvalid/awready/wready %b want 000", {bus.bvalid, bus.awready, bus.wready});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.awready, bus.wready} !== 2'b11 || slv_reg[127:96] !== 32'h12345678)
      $display("FAIL wfirst_readies_back: awready/wready %b reg3 %h want 11 12345678",
               {bus.awready, bus.wready}, slv_reg[127:96]);
    else n_pass++;
  endtask

  task automatic test_simul_rw();
    logic [1:0]  resp;
    logic [31:0] d;
    bit          ok;
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 4'h8; bus.awvalid = 1'b1;
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 4'h8; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h3)
      $display("FAIL simul_old_value: rvalid %b rdata %h want 1 00000003", bus.rvalid, bus.rdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h3 || bus.bvalid !== 1'b1)
      $display("FAIL simul_r_held: rvalid %b rdata %h bvalid %b want 1 00000003 1",
               bus.rvalid, bus.rdata, bus.bvalid);
    else n_pass++;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    axi_read(4'h8, d, resp, ok);
    n_checks++;
    if (!ok || d !== 32'h55)
      $display("FAIL simul_new_value: rdata %h want 00000055", d);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    logic [1:0]  resp;
    logic [31:0] d;
    bit          ok, stale;
    @(negedge clk);
    @(negedge clk);
    bus.awaddr = 4'h0; bus.awvalid = 1'b1;
    bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 4'h4; bus.arvalid = 1'b1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.bvalid, bus.rvalid} !== 2'b11)
      $display("FAIL inflight_setup: bvalid/rvalid %b want 11", {bus.bvalid, bus.rvalid});
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.arready} !== 4'b0000 || slv_reg !== 128'h0)
      $display("FAIL inflight_async_clear: b/r valid, aw/ar ready %b slv %h want 0000 0",
               {bus.bvalid, bus.rvalid, bus.awready, bus.arready}, slv_reg);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.bvalid || bus.rvalid) stale = 1'b1;
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
    n_checks++;
    if (stale) $display("FAIL inflight_stale: response seen after release, want none");
    else n_pass++;
    axi_read(4'h0, d, resp, ok);
    n_checks++;
    if (!ok || d !== 32'h0) $display("FAIL inflight_reg0: rdata %h want 00000000", d);
    else n_pass++;
    axi_read(4'h4, d, resp, ok);
    n_checks++;
    if (!ok || d !== 32'h0) $display("FAIL inflight_reg1: rdata %h want 00000000", d);
    else n_pass++;
  endtask

`ifdef MATRIX_DEMO_WR_PULSE_EN
  task automatic test_wr_pulse();
    logic [1:0] resp;
    bit         ok;
    int         before [4];
    for (int k = 0; k < 4; k++) before[k] = pulse_cnt[k];
    axi_write(4'hC, 32'hCAFE, 4'hF, resp, ok);
    @(negedge clk);
    n_checks++;
    if (pulse_cnt[3] - before[3] != 1 || pulse_cnt[0] != before[0] ||
        pulse_cnt[1] != before[1] || pulse_cnt[2] != before[2])
      $display("FAIL pulse_reg3: counts %0d %0d %0d %0d want 0 0 0 1",
               pulse_cnt[0] - before[0], pulse_cnt[1] - before[1],
               pulse_cnt[2] - before[2], pulse_cnt[3] - before[3]);
    else n_pass++;
    for (int k = 0; k < 4; k++) before[k] = pulse_cnt[k];
    axi_write(4'hC, 32'h1111, 4'h0, resp, ok);
    @(negedge clk);
    n_checks++;
    if (pulse_cnt[3] != before[3] || slv_reg[127:96] !== 32'hCAFE)
      $display("FAIL pulse_zero_strb: pulses %0d reg3 %h want 0 0000cafe",
               pulse_cnt[3] - before[3], slv_reg[127:96]);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_wstrb();
    test_w_before_aw();
    test_simul_rw();
    test_reset_inflight();
`ifdef MATRIX_DEMO_WR_PULSE_EN
    test_wr_pulse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
